alu_seq_exec: RTL and testbench
===============================

# alu_seq_exec

Execute-stage ALU directly downstream of the ALU controller: consumes the 4-bit `Operation` code plus two operands and produces `ALUResult` and `Zero` for the branch and writeback logic. Logic, add and compare operations complete in one cycle. Shifts use an iterative one-bit-per-cycle shifter to save area. A valid/ready handshake on both sides lets the pipeline stall while a shift is in progress.

## Interface
- `WIDTH`, default 32: operand and result width; shift amount is `SrcB[$clog2(WIDTH)-1:0]`.

- `clk`  input  1  rising-edge clock
- `reset`  input  1  synchronous, active-high reset
- `in_valid`  input  1  operands and `Operation` are valid this cycle
- `in_ready`  output  1  block accepts a new operation this cycle
- `Operation`  input  4  operation code from the ALU controller
- `SrcA`  input  WIDTH  operand A
- `SrcB`  input  WIDTH  operand B / shift amount
- `out_valid`  output  1  `ALUResult`/`Zero` valid
- `out_ready`  input  1  consumer takes the result this cycle
- `ALUResult`  output  WIDTH  registered result
- `Zero`  output  1  `out_valid && (ALUResult == 0)`

## Operation
- Encoding:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 XOR
  - 0100 SLL
  - 0101 SRL
  - 0111 SRA
  - 1000 EQ: result 1 if `SrcA==SrcB`, else 0
  - 1100 SLT: signed less-than, result 1/0
  - any other code: result 0, single-cycle
- ADD wraps modulo 2^WIDTH; no carry or overflow output.
- The FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - `in_ready=1`.
  - On `in_valid` with a non-shift op: compute and register the result, go to DONE.
  - On a shift op with shamt != 0: latch `SrcA` into the shift register, load the down-counter with shamt, go to SHIFT.
  - On a shift op with shamt == 0: register `SrcA` unchanged, go to DONE.
- SHIFT:
  - Each cycle, shift the register by one bit (SLL: left with 0 in; SRL: right with 0 in; SRA: right with the MSB replicated) and decrement the counter.
  - When the counter reaches 1, the final shift is written to `ALUResult` and the FSM goes to DONE.
  - `in_ready=0` throughout.
- DONE:
  - `out_valid=1`; `ALUResult` is held stable until the consumer accepts.
  - `out_ready=1` without a new input: go to IDLE.
  - `in_ready = out_ready` in DONE. If `out_ready && in_valid`, the new op is accepted in the same cycle; the next state follows the IDLE rules for that op (back-to-back).
- Operands and `Operation` are sampled only on the accept cycle (`in_valid && in_ready`); later changes on the inputs have no effect.

## Timing
- Reset values:
  - state IDLE
  - `in_ready=1`
  - `out_valid=0`
  - `ALUResult=0`
  - `Zero=0`
  - shift register and counter 0
- Latency from the accept edge to `out_valid=1`:
  - non-shift op, or shift with shamt 0: 1 cycle
  - shift with shamt n: 1+n cycles (maximum 1+(WIDTH-1) = 32 for WIDTH=32)
- Throughput for single-cycle ops: one per cycle while `out_ready` is held high (DONE→DONE with accept).
- `out_ready` asserted in IDLE or SHIFT is ignored.
- `in_valid` asserted while `in_ready=0` is not accepted; the upstream stage must hold its inputs.
- A `reset` high in any state, including mid-shift or DONE with a result pending, returns everything to the reset values on that edge. The pending result is discarded and no `out_valid` pulse appears.
- `in_ready` and `Zero` are combinational from state/`out_ready` and the registers respectively; every other output is registered.

## Test plan
- Reset, then ADD with `SrcA=0xFFFF_FFFF`, `SrcB=1` → one cycle later `out_valid=1`, `ALUResult=0`, `Zero=1`.
- SRA with `SrcA=0x8000_0000`, `SrcB=4` → `in_ready=0` for 4 cycles, then `out_valid=1` on cycle 5, `ALUResult=0xF800_0000`.
- SLL with shamt 0, `SrcA=0x1234_5678` → 1-cycle latency, `ALUResult=0x1234_5678`; SLL with shamt 31, `SrcA=1` → latency 32, `ALUResult=0x8000_0000`.
- Back-to-back with `out_ready=1`, `in_valid=1`:
  - Stimulus: SLT(-1,1), then EQ(5,5), then XOR(0xF0,0xFF).
  - Required response: results 1, 1, 0x0F on three consecutive cycles.
  - Same sequence with `out_ready=0` for 3 cycles: first result held stable and `in_ready=0` until `out_ready` rises.
- Reset asserted on the 2nd cycle of a SRL by 10 → next cycle `out_valid=0`, `in_ready=1`. A following OR(0x0F,0xF0) returns 0xFF with 1-cycle latency.
- Undefined code 1111 with `SrcA=SrcB=7` → `ALUResult=0`, `Zero=1`, 1-cycle latency.

Source files
------------

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: logic/add/compare in one cycle, shifts iterate one bit per cycle.
// Latency: 1 cycle for non-shift ops and zero-amount shifts, 1+shamt cycles for shifts.
// Backpressure: in_ready drops while shifting or while a result waits for out_ready.
module alu_seq_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] CNT_ONE = SW'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shnext, op_res, result;
  logic [SW-1:0]    cnt, shamt;
  logic [1:0]       kind;
  logic             is_shift, start_shift, accept;

  assign shamt       = SrcB[SW-1:0];
  assign is_shift    = (Operation == 4'b0100) || (Operation == 4'b0101) ||
                       (Operation == 4'b0111);
  assign start_shift = is_shift && (shamt != '0);

  // A new op can enter when idle, or when the held result leaves this same cycle.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign ALUResult = result;
  assign Zero      = out_valid && (result == '0);

  // Single-cycle result; a zero-amount shift passes SrcA through unchanged.
  always_comb begin
    op_res = '0;
    case (Operation)
      4'b0000: op_res = SrcA & SrcB;
      4'b0001: op_res = SrcA | SrcB;
      4'b0010: op_res = SrcA + SrcB;
      4'b0011: op_res = SrcA ^ SrcB;
      4'b0100, 4'b0101, 4'b0111: op_res = SrcA;
      4'b1000: op_res[0] = (SrcA == SrcB);
      4'b1100: op_res[0] = ($signed(SrcA) < $signed(SrcB));
      default: op_res = '0;
    endcase
  end

  // One-bit step of the iterative shifter; kind holds Operation[1:0] of the shift.
  always_comb begin
    shnext = '0;
    case (kind)
      2'b00:   shnext = {shreg[WIDTH-2:0], 1'b0};
      2'b01:   shnext = {1'b0, shreg[WIDTH-1:1]};
      default: shnext = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: an accepted op picks SHIFT or DONE the same way from IDLE or DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) state_nxt = start_shift ? SHIFT : DONE;
      end
      SHIFT: begin
        if (cnt == CNT_ONE) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) state_nxt = start_shift ? SHIFT : DONE;
          else          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, step the shifter, write the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg  <= '0;
      cnt    <= '0;
      kind   <= '0;
      result <= '0;
    end else if (accept) begin
      if (start_shift) begin
        shreg <= SrcA;
        cnt   <= shamt;
        kind  <= Operation[1:0];
      end else begin
        result <= op_res;
      end
    end else if (state == SHIFT) begin
      shreg <= shnext;
      cnt   <= cnt - CNT_ONE;
      if (cnt == CNT_ONE) result <= shnext;
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA, SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  alu_seq_exec #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALUResult(ALUResult), .Zero(Zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every transfer (out_valid && out_ready).
  always begin
    @(negedge clk);
    #2;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got 0x%0h expected none", ALUResult);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("result", {32'b0, ALUResult}, {32'b0, e});
        chk("zero", {63'b0, Zero}, {63'b0, (e == 32'b0)});
      end
    end
  end

  // Present an op and hold it until accepted; returns just before the accept edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit push);
    int n;
    @(negedge clk);
    in_valid = 1'b1; Operation = op; SrcA = a; SrcB = b;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("accept_wait", {63'b0, in_ready}, 64'd1);
    if (push) exp_q.push_back(exp);
  endtask

  // Issue one op with out_ready high and measure latency and busy (in_ready low) cycles.
  task automatic run_lat(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input int lat, input int busy);
    int cyc, nb;
    bit seen;
    out_ready = 1'b1;
    issue(op, a, b, exp, 1'b1);
    cyc = 0; nb = 0; seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      cyc++;
      if (!in_ready) nb++;
      if (out_valid) seen = 1'b1;
    end
    chk({name, "_latency"}, 64'(cyc), 64'(lat));
    chk({name, "_busy"}, 64'(nb), 64'(busy));
  endtask

  initial begin
    int hits;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    Operation = 4'b0; SrcA = '0; SrcB = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_result", {32'b0, ALUResult}, 64'd0);
    chk("rst_zero", {63'b0, Zero}, 64'd0);

    // Directed vectors: op, A, B, expected, latency, busy cycles.
    run_lat("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0);
    run_lat("sra4", 4'b0111, 32'h8000_0000, 32'd4, 32'hF800_0000, 5, 4);
    run_lat("sll0", 4'b0100, 32'h1234_5678, 32'd0, 32'h1234_5678, 1, 0);
    run_lat("sll31", 4'b0100, 32'h1, 32'd31, 32'h8000_0000, 32, 31);
    run_lat("srl8", 4'b0101, 32'hF000_0000, 32'h0000_0108, 32'h00F0_0000, 9, 8);
    run_lat("sra_pos", 4'b0111, 32'h4000_0000, 32'd3, 32'h0800_0000, 4, 3);
    run_lat("and", 4'b0000, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1, 0);
    run_lat("slt_signed", 4'b1100, 32'd5, 32'hFFFF_FFFD, 32'h0, 1, 0);
    run_lat("eq_ne", 4'b1000, 32'd5, 32'd6, 32'h0, 1, 0);
    run_lat("undef_6", 4'b0110, 32'hABCD_0000, 32'd2, 32'h0, 1, 0);
    run_lat("undef_f", 4'b1111, 32'd7, 32'd7, 32'h0, 1, 0);

    // Back-to-back with out_ready high: results on three consecutive cycles.
    out_ready = 1'b1;
    issue(4'b1100, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1);
    issue(4'b1000, 32'd5, 32'd5, 32'd1, 1'b1);
    chk("b2b_valid1", {63'b0, out_valid}, 64'd1);
    issue(4'b0011, 32'hF0, 32'hFF, 32'h0F, 1'b1);
    chk("b2b_valid2", {63'b0, out_valid}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("b2b_valid3", {63'b0, out_valid}, 64'd1);
    @(negedge clk);

    // Same sequence with out_ready low for three cycles: result held, in_ready low.
    out_ready = 1'b0;
    issue(4'b1100, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1);
    @(negedge clk);
    Operation = 4'b1000; SrcA = 32'd5; SrcB = 32'd5;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("hold_valid", {63'b0, out_valid}, 64'd1);
      chk("hold_result", {32'b0, ALUResult}, 64'd1);
      chk("hold_in_ready", {63'b0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    #0;
    chk("release_in_ready", {63'b0, in_ready}, 64'd1);
    exp_q.push_back(32'd1);
    issue(4'b0011, 32'hF0, 32'hFF, 32'h0F, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the second cycle of an SRL by 10 discards the pending shift.
    issue(4'b0101, 32'hFFFF_0000, 32'd10, 32'h0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("mid_rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("mid_rst_result", {32'b0, ALUResult}, 64'd0);
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) hits++;
    end
    chk("no_stale_pulse", 64'(hits), 64'd0);
    run_lat("or_after_rst", 4'b0001, 32'h0F, 32'hF0, 32'hFF, 1, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
